// File: rtl/uart_console.sv
// uart_console: echo/display endpoint between the uart byte handshake and the display path.
// Received bytes are queued in a TX FIFO for echo (sent one at a time through the
// tx_send/tx_sent handshake). They are also shifted into a display register, either
// as raw bytes or as parsed hexadecimal digits.
//
// Ports:
//   clk, rstn          clock, asynchronous active-low reset
//   mode               0 = raw byte shift, 1 = hex-digit parse (CR clears)
//   echo_en            queue received bytes for transmit
//   rx_data, rx_valid  received byte and its one-cycle strobe
//   tx_data, tx_send   byte to transmit and its one-cycle request pulse
//   tx_sent            transmit-complete pulse from the uart core
//   disp_value         display register
//   fifo_count         TX FIFO occupancy
//   overflow           sticky echo-drop flag; clr_overflow clears it
module uart_console #(
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned DISP_BYTES = 4,
  localparam int unsigned DW = 8 * DISP_BYTES,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          mode,
  input  logic          echo_en,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  output logic [7:0]    tx_data,
  output logic          tx_send,
  input  logic          tx_sent,
  output logic [DW-1:0] disp_value,
  output logic [CW-1:0] fifo_count,
  output logic          overflow,
  input  logic          clr_overflow
);

  localparam logic [CW-1:0] FullCount = CW'(DEPTH);

  typedef enum logic [0:0] {StIdle, StWait} state_e;

  state_e          state_q, state_d;
  logic [7:0]      mem [DEPTH];
  logic [AW-1:0]   wptr_q, rptr_q;
  logic [CW-1:0]   count_q, count_d;
  logic [7:0]      tx_data_q, tx_data_d;
  logic            tx_send_q, tx_send_d;
  logic            overflow_q, overflow_d;
  logic [DW-1:0]   disp_q, disp_d;

  logic            pop, push, drop, push_req, full;
  logic            is_hex;
  logic [3:0]      nibble;

  // TX FSM: pop the head in IDLE, then hold tx_data until tx_sent.
  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    tx_send_d = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop       = 1'b1;
          tx_send_d = 1'b1;
          tx_data_d = mem[rptr_q];
          state_d   = StWait;
        end
      end
      StWait: begin
        if (tx_sent) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // A push to a full FIFO is still accepted when the head leaves in the same cycle.
  always_comb begin
    push_req = rx_valid & echo_en;
    full     = (count_q == FullCount);
    push     = push_req & (~full | pop);
    drop     = push_req & full & ~pop;
    count_d  = count_q;
    unique case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    // Set wins over clear.
    overflow_d = drop ? 1'b1 : (clr_overflow ? 1'b0 : overflow_q);
  end

  // Hex-digit decode for parse mode.
  always_comb begin
    is_hex = 1'b1;
    nibble = 4'h0;
    if (rx_data >= 8'h30 && rx_data <= 8'h39) begin
      nibble = 4'(rx_data - 8'h30);
    end else if (rx_data >= 8'h61 && rx_data <= 8'h66) begin
      nibble = 4'(rx_data - 8'h57);
    end else if (rx_data >= 8'h41 && rx_data <= 8'h46) begin
      nibble = 4'(rx_data - 8'h37);
    end else begin
      is_hex = 1'b0;
    end
  end

  always_comb begin
    disp_d = disp_q;
    if (rx_valid) begin
      if (!mode) begin
        disp_d = (disp_q << 8) | DW'(rx_data);
      end else if (is_hex) begin
        disp_d = (disp_q << 4) | DW'(nibble);
      end else if (rx_data == 8'h0D) begin
        disp_d = '0;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q    <= StIdle;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      tx_data_q  <= '0;
      tx_send_q  <= 1'b0;
      overflow_q <= 1'b0;
      disp_q     <= '0;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      tx_data_q  <= tx_data_d;
      tx_send_q  <= tx_send_d;
      overflow_q <= overflow_d;
      disp_q     <= disp_d;
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
    end
  end

  // Storage needs no reset; occupancy is tracked by the pointers and count.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= rx_data;
  end

  assign tx_data    = tx_data_q;
  assign tx_send    = tx_send_q;
  assign disp_value = disp_q;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
